// File: rtl/pipe_adder_pkg.sv
// Shared helpers for the pipelined add/subtract unit.
// Covers chunk sizing and the legality test for the WIDTH/STAGES pair.
package pipe_adder_pkg;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// The master drives operands and out_ready; the slave (the adder) drives the rest.
interface pipe_adder_if #(
  parameter int WIDTH = 32
);
  import pipe_adder_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/pipe_adder_stage.sv
// One chunk of the ripple pipeline.
// Adds a CW-bit slice plus the carry and registers both the sum and the carry-out.
module pipe_adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  input  logic          i_cin,
  output logic [CW-1:0] o_sum,
  output logic          o_cout
);
  logic [CW:0]   w_full;
  logic [CW-1:0] r_sum;
  logic          r_cout;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CW{1'b0}}, i_cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (i_en) begin
      r_sum  <= w_full[CW-1:0];
      r_cout <= w_full[CW];
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;
endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract unit with one chunk added per stage.
// A single global stall holds every stage whenever the result is not being taken.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int STAGES   = 4,
  parameter int SATURATE = 0
) (
  input logic         clk,
  input logic         rst_n,
  pipe_adder_if.slave bus
);
  localparam int CW     = chunk_w(WIDTH, STAGES);
  localparam bit CFG_OK = cfg_ok(WIDTH, STAGES);

  if (!CFG_OK) begin : g_cfg_err
    $error("pipe_adder: STAGES must divide WIDTH and lie in 1..WIDTH");
  end

  logic              w_adv;
  logic [WIDTH-1:0]  w_b_eff;
  logic [WIDTH-1:0]  w_ca;
  logic [WIDTH-1:0]  w_cb;
  logic [WIDTH-1:0]  w_sums;
  logic [WIDTH-1:0]  w_raw;
  logic [STAGES-1:0] w_ci;
  logic [STAGES-1:0] w_co;
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_sub;
  logic              r_sa;
  logic              r_sb;

  // Subtraction is A + ~B + !cin, so B and the carry are conditioned on entry.
  assign w_b_eff      = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign w_adv        = !r_valid[STAGES-1] || bus.out_ready;
  assign bus.in_ready = w_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_sub   <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
    end else if (w_adv) begin
      r_valid[0] <= bus.in_valid;
      r_sub[0]   <= bus.in_sub;
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_sub[k]   <= r_sub[k-1];
      end
      r_sa <= w_ca[WIDTH-1];
      r_sb <= w_cb[WIDTH-1];
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign w_ca[CW-1:0] = bus.in_a[CW-1:0];
      assign w_cb[CW-1:0] = w_b_eff[CW-1:0];
      assign w_ci[0]      = bus.in_sub ^ bus.in_cin;
    end else begin : g_next
      assign w_ca[gi*CW +: CW] = g_skew[gi-1].r_a[CW-1:0];
      assign w_cb[gi*CW +: CW] = g_skew[gi-1].r_b[CW-1:0];
      assign w_ci[gi]          = w_co[gi-1];
    end

    pipe_adder_stage #(.CW(CW)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_adv),
      .i_a    (w_ca[gi*CW +: CW]),
      .i_b    (w_cb[gi*CW +: CW]),
      .i_cin  (w_ci[gi]),
      .o_sum  (w_sums[gi*CW +: CW]),
      .o_cout (w_co[gi])
    );
  end

  // r_a/r_b hold the not-yet-added upper chunks for the beat in stage gi;
  // r_lo holds the finished low chunks for the beat in stage gi+1.
  for (genvar gi = 0; gi < STAGES - 1; gi++) begin : g_skew
    localparam int SW = WIDTH - (gi + 1) * CW;
    logic [SW-1:0]          r_a;
    logic [SW-1:0]          r_b;
    logic [SW-1:0]          w_a_nx;
    logic [SW-1:0]          w_b_nx;
    logic [(gi+1)*CW-1:0]   r_lo;
    logic [(gi+1)*CW-1:0]   w_lo_nx;

    if (gi == 0) begin : g_first
      assign w_a_nx  = bus.in_a[WIDTH-1:CW];
      assign w_b_nx  = w_b_eff[WIDTH-1:CW];
      assign w_lo_nx = w_sums[CW-1:0];
    end else begin : g_next
      assign w_a_nx  = g_skew[gi-1].r_a[SW+CW-1:CW];
      assign w_b_nx  = g_skew[gi-1].r_b[SW+CW-1:CW];
      assign w_lo_nx = {w_sums[gi*CW +: CW], g_skew[gi-1].r_lo};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_a  <= '0;
        r_b  <= '0;
        r_lo <= '0;
      end else if (w_adv) begin
        r_a  <= w_a_nx;
        r_b  <= w_b_nx;
        r_lo <= w_lo_nx;
      end
    end
  end

  if (STAGES == 1) begin : g_out_one
    assign w_raw = w_sums;
  end else begin : g_out_cat
    assign w_raw = {w_sums[WIDTH-1 -: CW], g_skew[STAGES-2].r_lo};
  end

  // Clamping uses the final carry, so it is applied after the last register.
  always_comb begin
    bus.out_sum = w_raw;
    if ((SATURATE != 0) && !r_sub[STAGES-1] && w_co[STAGES-1]) begin
      bus.out_sum = '1;
    end else if ((SATURATE != 0) && r_sub[STAGES-1] && !w_co[STAGES-1]) begin
      bus.out_sum = '0;
    end
  end

  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.out_cout  = w_co[STAGES-1];
  assign bus.out_ovf   = (r_sa == r_sb) && (w_raw[WIDTH-1] != r_sa);
endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: four configurations (4/sat0, 4/sat1, 1/sat0, 8/sat0) run side by side
// against an arithmetic reference model plus directed vectors with literal results.
module tb_pipe_adder;
  localparam int N = 4;

  function automatic int st_of(input int i);
    case (i)
      0, 1:    return 4;
      2:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic int sat_of(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0] in_valid_d, out_ready_d, in_cin_d, in_sub_d;
  logic [31:0]  a_d [N];
  logic [31:0]  b_d [N];
  logic [N-1:0] rdy_q, ov_q, cout_q, ovf_q;
  logic [31:0]  sum_q [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    pipe_adder_if #(.WIDTH(32)) bus ();
    assign bus.in_valid  = in_valid_d[gi];
    assign bus.in_a      = a_d[gi];
    assign bus.in_b      = b_d[gi];
    assign bus.in_cin    = in_cin_d[gi];
    assign bus.in_sub    = in_sub_d[gi];
    assign bus.out_ready = out_ready_d[gi];
    assign rdy_q[gi]     = bus.in_ready;
    assign ov_q[gi]      = bus.out_valid;
    assign sum_q[gi]     = bus.out_sum;
    assign cout_q[gi]    = bus.out_cout;
    assign ovf_q[gi]     = bus.out_ovf;

    pipe_adder #(.WIDTH(32), .STAGES(st_of(gi)), .SATURATE(sat_of(gi))) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: plain integer arithmetic; returns {sum, cout, ovf}.
  function automatic logic [33:0] ref_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic cin, input logic sub, input int sat);
    longint ua, ub, sa, sb, ci, u, s;
    logic   cout, ovf;
    logic [31:0] sum;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ci = longint'({63'd0, cin});
    if (!sub) begin
      u    = ua + ub + ci;
      s    = sa + sb + ci;
      cout = (u >= 64'sh1_0000_0000);
    end else begin
      u    = ua - ub - ci;
      s    = sa - sb - ci;
      cout = (u >= 64'sd0);
    end
    ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    sum = u[31:0];
    if (sat != 0) begin
      if (!sub && cout) sum = 32'hFFFF_FFFF;
      else if (sub && !cout) sum = 32'h0;
    end
    return {sum, cout, ovf};
  endfunction

  typedef struct {
    logic [33:0] r;
    int          adv_at;
  } exp_t;

  exp_t        expq [N][$];
  int          adv_cnt [N];
  int          n_out [N];
  bit          seen [N];
  bit          stalled [N];
  logic [33:0] held [N];

  // Single compare process: every negedge, every configuration.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        chk($sformatf("rst_out_valid[%0d]", i), 64'(ov_q[i]), 64'd0);
        chk($sformatf("rst_out_sum[%0d]", i), 64'(sum_q[i]), 64'd0);
        chk($sformatf("rst_in_ready[%0d]", i), 64'(rdy_q[i]), 64'd1);
        expq[i].delete();
        seen[i]    = 1'b0;
        stalled[i] = 1'b0;
      end else begin
        logic [33:0] got;
        got = {sum_q[i], cout_q[i], ovf_q[i]};
        if (ov_q[i]) begin
          if (expq[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_out[%0d] actual=%0h required=no beat", i, got);
          end else begin
            if (!seen[i]) begin
              chk($sformatf("latency[%0d]", i), 64'(adv_cnt[i] - expq[i][0].adv_at), 64'(st_of(i)));
              seen[i] = 1'b1;
            end
            if (stalled[i]) chk($sformatf("hold[%0d]", i), 64'(got), 64'(held[i]));
            chk($sformatf("result[%0d]", i), 64'(got), 64'(expq[i][0].r));
            if (out_ready_d[i]) begin
              void'(expq[i].pop_front());
              n_out[i]++;
              seen[i]    = 1'b0;
              stalled[i] = 1'b0;
            end else begin
              stalled[i] = 1'b1;
              held[i]    = got;
            end
          end
        end
        chk($sformatf("in_ready[%0d]", i), 64'(rdy_q[i]), 64'(!(ov_q[i] && !out_ready_d[i])));
        if (in_valid_d[i] && rdy_q[i]) begin
          exp_t e;
          e.r      = ref_calc(a_d[i], b_d[i], in_cin_d[i], in_sub_d[i], sat_of(i));
          e.adv_at = adv_cnt[i];
          expq[i].push_back(e);
        end
        if (rdy_q[i]) adv_cnt[i]++;
      end
    end
  end

  task automatic drive_all(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    for (int i = 0; i < N; i++) begin
      a_d[i] = a;
      b_d[i] = b;
    end
    in_cin_d   = {N{cin}};
    in_sub_d   = {N{sub}};
    in_valid_d = '1;
  endtask

  task automatic run_vec(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                         input logic [31:0] s0, input logic c0, input logic o0, input logic [31:0] s1);
    logic [33:0] m;
    bit          got [N];
    m = ref_calc(a, b, cin, sub, 0);
    chk($sformatf("model_sat0 %h%s%h", a, sub ? "-" : "+", b), 64'(m), 64'({s0, c0, o0}));
    m = ref_calc(a, b, cin, sub, 1);
    chk($sformatf("model_sat1 %h%s%h", a, sub ? "-" : "+", b), 64'(m), 64'({s1, c0, o0}));
    for (int i = 0; i < N; i++) got[i] = 1'b0;
    @(posedge clk);
    #1;
    out_ready_d = '1;
    drive_all(a, b, cin, sub);
    @(posedge clk);
    #1;
    in_valid_d = '0;
    for (int c = 1; c <= 12; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!got[i] && ov_q[i]) begin
          got[i] = 1'b1;
          chk($sformatf("vec_latency[%0d]", i), 64'(c), 64'(st_of(i)));
          chk($sformatf("vec_sum[%0d] %h%s%h", i, a, sub ? "-" : "+", b), 64'(sum_q[i]),
              64'((sat_of(i) != 0) ? s1 : s0));
          chk($sformatf("vec_cout[%0d]", i), 64'(cout_q[i]), 64'(c0));
          chk($sformatf("vec_ovf[%0d]", i), 64'(ovf_q[i]), 64'(o0));
        end
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < N; i++) begin
      if (!got[i]) begin
        total++;
        bad++;
        $display("FAIL vec_timeout[%0d] actual=no out_valid required=out_valid within 12 cycles", i);
      end
    end
  endtask

  logic [31:0] ra [16];
  logic [31:0] rb [16];
  logic [15:0] rc, rs;
  int          idx [N];
  bit          took [N];
  logic [6:0]  pat_v;

  initial begin
    rst_n       = 1'b0;
    in_valid_d  = '0;
    out_ready_d = '1;
    in_cin_d    = '0;
    in_sub_d    = '0;
    for (int i = 0; i < N; i++) begin
      a_d[i]     = '0;
      b_d[i]     = '0;
      adv_cnt[i] = 0;
      n_out[i]   = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("post_rst_valid[%0d]", i), 64'(ov_q[i]), 64'd0);
      chk($sformatf("post_rst_sum[%0d]", i), 64'(sum_q[i]), 64'd0);
      chk($sformatf("post_rst_ready[%0d]", i), 64'(rdy_q[i]), 64'd1);
    end

    run_vec(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'h0000_0100);
    run_vec(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 32'h0100_0000);
    run_vec(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'hFFFF_FFFF);
    run_vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000);
    run_vec(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0000_0000);
    run_vec(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0001);
    run_vec(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 32'h7FFF_FFFF);
    run_vec(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000);

    // Reset with three beats still in flight; nothing may surface afterwards.
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      drive_all(32'h1111_0000 + 32'(k), 32'h0000_0100, 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    in_valid_d = '0;
    rst_n      = 1'b0;
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("midrst_valid[%0d]", i), 64'(ov_q[i]), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) chk($sformatf("no_stale[%0d]", i), 64'(ov_q[i]), 64'd0);
      @(posedge clk);
      #1;
    end

    // Back-to-back random beats under a repeating stall pattern.
    for (int k = 0; k < 16; k++) begin
      ra[k] = $urandom;
      rb[k] = $urandom;
    end
    ra[3] = 32'hFFFF_FFFF;
    rb[3] = 32'hFFFF_FFFF;
    rc    = 16'($urandom);
    rs    = 16'($urandom);
    pat_v = 7'b1001101;
    for (int i = 0; i < N; i++) begin
      idx[i]   = 0;
      n_out[i] = 0;
    end
    begin
      int cyc;
      bit done;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 600) begin
        out_ready_d = {N{pat_v[cyc % 7]}};
        for (int i = 0; i < N; i++) begin
          if (idx[i] < 16) begin
            in_valid_d[i] = 1'b1;
            a_d[i]        = ra[idx[i]];
            b_d[i]        = rb[idx[i]];
            in_cin_d[i]   = rc[idx[i]];
            in_sub_d[i]   = rs[idx[i]];
          end else begin
            in_valid_d[i] = 1'b0;
          end
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) took[i] = in_valid_d[i] && rdy_q[i];
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (took[i]) idx[i]++;
        cyc++;
        done = 1'b1;
        for (int i = 0; i < N; i++) if (idx[i] < 16 || n_out[i] < 16) done = 1'b0;
      end
    end
    in_valid_d  = '0;
    out_ready_d = '1;
    for (int i = 0; i < N; i++) chk($sformatf("beats_out[%0d]", i), 64'(n_out[i]), 64'd16);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1, "global timeout");
  end
endmodule
